data_memory_param: RTL and testbench

DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

---
 rtl/data_memory_param.sv | 161 ++++++++++++++++
 tb/tb_data_memory_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
// Byte-addressable 32-bit data memory with a fixed-latency request/response handshake.
// Stores commit and the load word is captured at acceptance; the response appears LATENCY edges later.
module data_memory_param #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [31:0] ram_address_load,
  input  logic [31:0] ram_address_store,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_busy,
  output logic        mem_valid,
  output logic        misaligned_fault
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              req, accept, respond;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] ld_idx, st_idx;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              st_mis, ld_mis;
  logic [31:0]       ld_word_q, ld_result;
  logic              rd_q, ld_mis_q, fault_q;
  logic [2:0]        lt_q;
  logic [1:0]        lane_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              addr_hi_unused;

  // Upper address bits intentionally ignored: the array wraps around.
  assign addr_hi_unused = ^{ram_address_load[31:ADDR_W+2], ram_address_store[31:ADDR_W+2]};
  assign ld_idx = ram_address_load[ADDR_W+1:2];
  assign st_idx = ram_address_store[ADDR_W+1:2];
  assign req    = mem_read_en | mem_write_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The response edge doubles as an IDLE edge so a held request issues back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = S_WAIT;
      cnt_d   = CNT_INIT;
    end else if (respond) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    mem_busy = (state_q == S_WAIT);
    respond  = mem_busy && (cnt_q == 2'd0);
    accept   = req && (!mem_busy || respond);
  end

  always_comb begin
    st_be   = '0;
    st_data = data_in;
    st_mis  = 1'b0;
    if (mem_write_en) begin
      case (store_type)
        3'b000: begin
          st_be   = 4'b0001 << ram_address_store[1:0];
          st_data = {4{data_in[7:0]}};
        end
        3'b001: begin
          if (ram_address_store[0]) st_mis = 1'b1;
          else begin
            st_be   = ram_address_store[1] ? 4'b1100 : 4'b0011;
            st_data = {2{data_in[15:0]}};
          end
        end
        3'b010: begin
          if (ram_address_store[1:0] != 2'b00) st_mis = 1'b1;
          else st_be = '1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_mis = 1'b0;
    if (mem_read_en) begin
      case (load_type)
        3'b001, 3'b101: ld_mis = ram_address_load[0];
        3'b010:         ld_mis = (ram_address_load[1:0] != 2'b00);
        default:        ld_mis = 1'b0;
      endcase
    end
  end

  // Nonblocking read returns the pre-store word on a same-edge read/write collision.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) mem[st_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
      ld_word_q <= mem[ld_idx];
    end
  end

  always_comb begin
    ld_byte   = ld_word_q[8*lane_q +: 8];
    ld_half   = lane_q[1] ? ld_word_q[31:16] : ld_word_q[15:0];
    ld_result = '0;
    case (lt_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_result = ld_word_q;
      3'b100:  ld_result = {24'd0, ld_byte};
      3'b101:  ld_result = {16'd0, ld_half};
      default: ld_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out         <= '0;
      mem_valid        <= 1'b0;
      misaligned_fault <= 1'b0;
      rd_q             <= 1'b0;
      lt_q             <= '0;
      lane_q           <= '0;
      ld_mis_q         <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      mem_valid        <= respond;
      misaligned_fault <= respond & fault_q;
      if (respond && rd_q && !ld_mis_q) data_out <= ld_result;
      if (accept) begin
        rd_q     <= mem_read_en;
        lt_q     <= load_type;
        lane_q   <= ram_address_load[1:0];
        ld_mis_q <= ld_mis;
        fault_q  <= ld_mis | st_mis;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: LATENCY=1 instance for data paths,
// LATENCY=3 instance for back-to-back timing and busy-time request filtering.
module tb_data_memory_param;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [2:0]  lt = '0, st = '0;
  logic [31:0] la = '0, sa = '0, din = '0;
  logic [31:0] dout;
  logic        busy, valid, fault;

  logic        rd3 = 1'b0, wr3 = 1'b0;
  logic [2:0]  lt3 = '0, st3 = '0;
  logic [31:0] la3 = '0, sa3 = '0, din3 = '0;
  logic [31:0] dout3;
  logic        busy3, valid3, fault3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_param #(.ADDR_W(10), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_read_en(rd_en), .mem_write_en(wr_en),
    .load_type(lt), .store_type(st), .ram_address_load(la), .ram_address_store(sa),
    .data_in(din), .data_out(dout), .mem_busy(busy), .mem_valid(valid),
    .misaligned_fault(fault)
  );

  data_memory_param #(.ADDR_W(10), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .mem_read_en(rd3), .mem_write_en(wr3),
    .load_type(lt3), .store_type(st3), .ram_address_load(la3), .ram_address_store(sa3),
    .data_in(din3), .data_out(dout3), .mem_busy(busy3), .mem_valid(valid3),
    .misaligned_fault(fault3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LATENCY=1 transaction: drive at negedge, accept at the next edge, respond one edge later.
  task automatic op1(input string tag, input logic rd, input logic wr,
                     input logic [2:0] ltype, input logic [2:0] stype,
                     input logic [31:0] laddr, input logic [31:0] saddr,
                     input logic [31:0] d, input logic exp_fault);
    @(negedge clk);
    rd_en = rd; wr_en = wr; lt = ltype; st = stype; la = laddr; sa = saddr; din = d;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    chk({tag, "_busy_acc"}, busy, 1'b1);
    chk({tag, "_valid_acc"}, valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_valid_rsp"}, valid, 1'b1);
    chk({tag, "_busy_rsp"}, busy, 1'b0);
    chk({tag, "_fault"}, fault, exp_fault);
  endtask

  initial begin
    #2;
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_busy3", busy3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op1("sw10", 0, 1, LW, SW, 0, 32'h10, 32'h8000_00F0, 0);
    chk("sw10_dout", dout, 32'h0);
    op1("lb10", 1, 0, LB, SW, 32'h10, 0, 0, 0);
    chk("lb10_dout", dout, 32'hFFFF_FFF0);
    op1("lbu13", 1, 0, LBU, SW, 32'h13, 0, 0, 0);
    chk("lbu13_dout", dout, 32'h0000_0080);
    op1("lhu12", 1, 0, LHU, SW, 32'h12, 0, 0, 0);
    chk("lhu12_dout", dout, 32'h0000_8000);
    op1("lh12", 1, 0, LH, SW, 32'h12, 0, 0, 0);
    chk("lh12_dout", dout, 32'hFFFF_8000);

    op1("sb11", 0, 1, LW, SB, 0, 32'h11, 32'h0000_00AB, 0);
    op1("lw10a", 1, 0, LW, SW, 32'h10, 0, 0, 0);
    chk("lw10a_dout", dout, 32'h8000_ABF0);

    op1("sw20", 0, 1, LW, SW, 0, 32'h20, 32'h0, 0);
    op1("sh21", 0, 1, LW, SH, 0, 32'h21, 32'h1234, 1);
    chk("sh21_dout", dout, 32'h8000_ABF0);
    op1("lw20a", 1, 0, LW, SW, 32'h20, 0, 0, 0);
    chk("lw20a_dout", dout, 32'h0);
    op1("sh22", 0, 1, LW, SH, 0, 32'h22, 32'h1234, 0);
    op1("lw20b", 1, 0, LW, SW, 32'h20, 0, 0, 0);
    chk("lw20b_dout", dout, 32'h1234_0000);
    op1("lw21mis", 1, 0, LW, SW, 32'h21, 0, 0, 1);
    chk("lw21mis_dout", dout, 32'h1234_0000);

    op1("sw40", 0, 1, LW, SW, 0, 32'h40, 32'h5, 0);
    op1("rw40", 1, 1, LW, SW, 32'h40, 32'h40, 32'hAAAA_AAAA, 0);
    chk("rw40_dout", dout, 32'h5);
    op1("lw40", 1, 0, LW, SW, 32'h40, 0, 0, 0);
    chk("lw40_dout", dout, 32'hAAAA_AAAA);

    op1("ldundef", 1, 0, 3'b011, SW, 32'h10, 0, 0, 0);
    chk("ldundef_dout", dout, 32'h0);
    op1("stundef", 0, 1, LW, 3'b111, 0, 32'h10, 32'hFFFF_FFFF, 0);
    chk("stundef_dout", dout, 32'h0);
    op1("lw10b", 1, 0, LW, SW, 32'h10, 0, 0, 0);
    chk("lw10b_dout", dout, 32'h8000_ABF0);

    op1("orfault", 1, 1, LW, SH, 32'h10, 32'h23, 32'hBEEF, 1);
    op1("lw20c", 1, 0, LW, SW, 32'h20, 0, 0, 0);
    chk("lw20c_dout", dout, 32'h1234_0000);

    op1("alias_rd", 1, 0, LW, SW, 32'h1010, 0, 0, 0);
    chk("alias_rd_dout", dout, 32'h8000_ABF0);
    op1("alias_wr", 0, 1, LW, SW, 0, 32'h1044, 32'h1234_5678, 0);
    op1("lw44", 1, 0, LW, SW, 32'h44, 0, 0, 0);
    chk("lw44_dout", dout, 32'h1234_5678);

    // Reset while a load+store is in flight.
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b1; lt = LW; st = SW; la = 32'h40; sa = 32'h50; din = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    chk("abort_busy_acc", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", valid, 1'b0);
    chk("abort_dout", dout, 32'h0);
    chk("abort_fault", fault, 1'b0);
    @(posedge clk); #1;
    chk("abort_valid_late", valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op1("lw50", 1, 0, LW, SW, 32'h50, 0, 0, 0);
    chk("lw50_dout", dout, 32'hDEAD_BEEF);

    // LATENCY=3: held store request accepted at E0, E3, E6; E7/E8 requests ignored while busy.
    @(negedge clk);
    wr3 = 1'b1; st3 = SW; sa3 = 32'h60; din3 = 32'h100;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("l3_busy_e%0d", k), busy3, 1'b1);
      chk($sformatf("l3_valid_e%0d", k), valid3, (k == 3 || k == 6) ? 1'b1 : 1'b0);
      din3 = (k >= 6) ? 32'h999 : 32'h101 + k;
    end
    wr3 = 1'b0;
    @(posedge clk); #1;
    chk("l3_valid_e9", valid3, 1'b1);
    chk("l3_busy_e9", busy3, 1'b0);
    @(negedge clk);
    rd3 = 1'b1; lt3 = LW; la3 = 32'h60;
    @(posedge clk); #1;
    rd3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("l3_rd_valid_early", valid3, 1'b0);
    @(posedge clk); #1;
    chk("l3_rd_valid", valid3, 1'b1);
    chk("l3_rd_dout", dout3, 32'h106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
